// File: rtl/free_ptr_pool.sv
// -----------------------------------------------------------------------------
// free_ptr_pool
//
// Free-pointer pool for the switch packet buffer. Every unused buffer pointer
// sits in a circular free list held in a single-clock RAM. One pointer goes out
// per granted allocation and one comes back per accepted release. After reset
// or an init_req pulse, a sequencer writes 0..DEPTH-1 into the list one entry
// per cycle, so the RAM needs no preload. DEPTH need not be a power of two.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   init_req   synchronous re-initialise pulse (restarts the fill sequence)
//   init_done  high while the pool is in RUN
//   alloc_req  request one pointer
//   alloc_vld  one-cycle strobe, alloc_ptr is valid
//   alloc_ptr  allocated pointer, holds its value while alloc_vld is low
//   rel_en     return rel_ptr to the pool
//   rel_ptr    pointer being returned
//   free_cnt   number of pointers currently free
//   empty      free_cnt == 0
//   full       free_cnt == DEPTH
//   low_wm     init_done && free_cnt <= LOW_WM
//   alloc_err  registered pulse, allocation request refused
//   rel_err    registered pulse, release dropped
// -----------------------------------------------------------------------------
module free_ptr_pool #(
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512,
    parameter int LOW_WM     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  alloc_req,
    output logic                  alloc_vld,
    output logic [ADDR_WIDTH-1:0] alloc_ptr,
    input  logic                  rel_en,
    input  logic [ADDR_WIDTH-1:0] rel_ptr,
    output logic [ADDR_WIDTH:0]   free_cnt,
    output logic                  empty,
    output logic                  full,
    output logic                  low_wm,
    output logic                  alloc_err,
    output logic                  rel_err
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Constants widened to the counter width so DEPTH == 2^ADDR_WIDTH still fits.
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LOW_WM_C = (ADDR_WIDTH+1)'(LOW_WM);
    localparam logic [ADDR_WIDTH-1:0] LAST_C   = ADDR_WIDTH'(DEPTH - 1);

    // Free-list storage
    logic [ADDR_WIDTH-1:0] mem [DEPTH];

    // State
    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] idx_q,       idx_d;
    logic [ADDR_WIDTH-1:0] rd_q,        rd_d;
    logic [ADDR_WIDTH-1:0] wr_q,        wr_d;
    logic [ADDR_WIDTH:0]   free_cnt_q,  free_cnt_d;
    logic                  alloc_vld_q, alloc_vld_d;
    logic [ADDR_WIDTH-1:0] alloc_ptr_q, alloc_ptr_d;
    logic                  alloc_err_q, alloc_err_d;
    logic                  rel_err_q,   rel_err_d;

    // RAM port controls and per-cycle decisions
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [ADDR_WIDTH-1:0] ram_wdata;
    logic                  ram_re;
    logic                  rel_ok;
    logic                  grant;
    logic                  rel_acc;
    logic                  bypass;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        free_cnt_d  = free_cnt_q;
        alloc_vld_d = 1'b0;
        alloc_ptr_d = alloc_ptr_q;
        alloc_err_d = 1'b0;
        rel_err_d   = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = wr_q;
        ram_wdata   = rel_ptr;
        ram_re      = 1'b0;
        grant       = 1'b0;
        rel_acc     = 1'b0;
        bypass      = 1'b0;
        rel_ok      = ({1'b0, rel_ptr} < DEPTH_C) && (free_cnt_q != DEPTH_C);

        if (init_req) begin
            // Re-initialise wins over everything; same-cycle requests are
            // dropped silently and outstanding pointers are forfeited.
            state_d    = ST_INIT;
            idx_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            free_cnt_d = '0;
        end else if (state_q == ST_INIT) begin
            ram_we      = 1'b1;
            ram_waddr   = idx_q;
            ram_wdata   = idx_q;
            alloc_err_d = alloc_req;
            rel_err_d   = rel_en;
            if (idx_q == LAST_C) begin
                state_d    = ST_RUN;
                free_cnt_d = DEPTH_C;
                wr_d       = '0;
                idx_d      = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            grant   = alloc_req && (free_cnt_q != '0);
            rel_acc = rel_en && rel_ok;
            // Empty list: a coinciding release is handed straight to the
            // requester without touching the RAM or the pointers.
            bypass  = alloc_req && (free_cnt_q == '0) && rel_acc;

            rel_err_d   = rel_en && !rel_ok;
            alloc_err_d = alloc_req && (free_cnt_q == '0) && !bypass;

            if (grant) begin
                ram_re      = 1'b1;
                rd_d        = next_ptr(rd_q);
                alloc_vld_d = 1'b1;
            end

            if (bypass) begin
                alloc_vld_d = 1'b1;
                alloc_ptr_d = rel_ptr;
            end else if (rel_acc) begin
                // Grant needs free_cnt > 0 and release needs free_cnt < DEPTH,
                // so rd != wr here and the write never collides with the read.
                ram_we = 1'b1;
                wr_d   = next_ptr(wr_q);
            end

            if (grant && !(rel_acc && !bypass)) begin
                free_cnt_d = free_cnt_q - 1'b1;
            end else if (!grant && rel_acc && !bypass) begin
                free_cnt_d = free_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: the list RAM has no reset; the fill sequencer defines its contents
    // before any entry can be read, and a reset would stop RAM inference.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // Registered read port doubles as the alloc_ptr hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_q <= '0;
        end else if (ram_re) begin
            alloc_ptr_q <= mem[rd_q];
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            free_cnt_q  <= '0;
            alloc_vld_q <= 1'b0;
            alloc_err_q <= 1'b0;
            rel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            free_cnt_q  <= free_cnt_d;
            alloc_vld_q <= alloc_vld_d;
            alloc_err_q <= alloc_err_d;
            rel_err_q   <= rel_err_d;
        end
    end

    assign init_done = (state_q == ST_RUN);
    assign alloc_vld = alloc_vld_q;
    assign alloc_ptr = alloc_ptr_q;
    assign free_cnt  = free_cnt_q;
    assign empty     = (free_cnt_q == '0);
    assign full      = (free_cnt_q == DEPTH_C);
    assign low_wm    = init_done && (free_cnt_q <= LOW_WM_C);
    assign alloc_err = alloc_err_q;
    assign rel_err   = rel_err_q;

endmodule

// File: tb/tb_free_ptr_pool.sv
// -----------------------------------------------------------------------------
// tb_free_ptr_pool
//
// Scoreboard bench for free_ptr_pool (DEPTH=12, ADDR_WIDTH=4, LOW_WM=2).
// The stimulus task updates a queue-based reference model of the free list and
// pushes the expected registered response; a monitor pops and compares it
// whenever the DUT raises alloc_vld, alloc_err or rel_err. Status outputs are
// compared against the model after every edge.
// -----------------------------------------------------------------------------
module tb_free_ptr_pool;

    localparam int AW     = 4;
    localparam int DEPTH  = 12;
    localparam int LOW_WM = 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          init_req  = 1'b0;
    logic          alloc_req = 1'b0;
    logic          rel_en    = 1'b0;
    logic [AW-1:0] rel_ptr   = '0;
    logic          init_done;
    logic          alloc_vld;
    logic [AW-1:0] alloc_ptr;
    logic [AW:0]   free_cnt;
    logic          empty;
    logic          full;
    logic          low_wm;
    logic          alloc_err;
    logic          rel_err;

    free_ptr_pool #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .LOW_WM     (LOW_WM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_req  (init_req),
        .init_done (init_done),
        .alloc_req (alloc_req),
        .alloc_vld (alloc_vld),
        .alloc_ptr (alloc_ptr),
        .rel_en    (rel_en),
        .rel_ptr   (rel_ptr),
        .free_cnt  (free_cnt),
        .empty     (empty),
        .full      (full),
        .low_wm    (low_wm),
        .alloc_err (alloc_err),
        .rel_err   (rel_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected registered response for one cycle
    typedef struct {
        int          stamp;
        bit          vld;
        bit [AW-1:0] ptr;
        bit          aerr;
        bit          rerr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: a FIFO of free pointers plus an INIT cycle counter.
    bit          m_init;
    int          m_icnt;
    int          m_free[$];
    bit [AW-1:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_status();
        check("init_done", 32'(init_done), 32'(!m_init));
        check("free_cnt",  32'(free_cnt),  32'(m_free.size()));
        check("empty",     32'(empty),     32'(m_free.size() == 0));
        check("full",      32'(full),      32'(m_free.size() == DEPTH));
        check("low_wm",    32'(low_wm),    32'(!m_init && m_free.size() <= LOW_WM));
        check("alloc_ptr_hold", 32'(alloc_ptr), 32'(m_last));
    endtask

    // Drive one cycle of inputs, advance the model, then check status after the edge.
    task automatic step(input bit ireq, input bit areq, input bit ren, input logic [AW-1:0] rptr);
        exp_t e;
        int   n;
        bit   rel_ok;
        bit   byp;
        init_req  = ireq;
        alloc_req = areq;
        rel_en    = ren;
        rel_ptr   = rptr;
        e = '{stamp: cyc + 1, vld: 1'b0, ptr: '0, aerr: 1'b0, rerr: 1'b0};
        if (ireq) begin
            m_init = 1'b1;
            m_icnt = 0;
            m_free.delete();
        end else if (m_init) begin
            e.aerr = areq;
            e.rerr = ren;
            m_icnt++;
            if (m_icnt == DEPTH) begin
                m_init = 1'b0;
                for (int i = 0; i < DEPTH; i++) m_free.push_back(i);
            end
        end else begin
            n      = m_free.size();
            rel_ok = ren && (int'(rptr) < DEPTH) && (n < DEPTH);
            e.rerr = ren && !rel_ok;
            byp    = 1'b0;
            if (areq) begin
                if (n > 0) begin
                    e.vld = 1'b1;
                    e.ptr = AW'(m_free.pop_front());
                end else if (rel_ok) begin
                    e.vld = 1'b1;
                    e.ptr = rptr;
                    byp   = 1'b1;
                end else begin
                    e.aerr = 1'b1;
                end
            end
            if (rel_ok && !byp) m_free.push_back(int'(rptr));
            if (e.vld) m_last = e.ptr;
        end
        if (e.vld || e.aerr || e.rerr) exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic do_reset(input int hold);
        init_req  = 1'b0;
        alloc_req = 1'b0;
        rel_en    = 1'b0;
        rel_ptr   = '0;
        rst_n     = 1'b0;
        exp_q.delete();
        m_init = 1'b1;
        m_icnt = 0;
        m_free.delete();
        m_last = '0;
        #1;
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_alloc_vld", 32'(alloc_vld), 32'd0);
        check("rst_alloc_ptr", 32'(alloc_ptr), 32'd0);
        check("rst_free_cnt",  32'(free_cnt),  32'd0);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_low_wm",    32'(low_wm),    32'd0);
        check("rst_alloc_err", 32'(alloc_err), 32'd0);
        check("rst_rel_err",   32'(rel_err),   32'd0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare each DUT response against the next expected entry.
    always @(negedge clk) begin
        if (rst_n && (alloc_vld || alloc_err || rel_err)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output @cyc %0d: got vld=%0b ptr=%0d aerr=%0b rerr=%0b, expected no response",
                         cyc, alloc_vld, alloc_ptr, alloc_err, rel_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_cycle", 32'(cyc),       32'(mon_e.stamp));
                check("alloc_vld",  32'(alloc_vld), 32'(mon_e.vld));
                if (mon_e.vld) check("alloc_ptr", 32'(alloc_ptr), 32'(mon_e.ptr));
                check("alloc_err",  32'(alloc_err), 32'(mon_e.aerr));
                check("rel_err",    32'(rel_err),   32'(mon_e.rerr));
            end
        end
    end

    initial begin
        #2;
        do_reset(2);

        // Fill sequence, then drain in order and over-allocate once.
        repeat (DEPTH) step(1'b0, 1'b0, 1'b0, '0);
        repeat (DEPTH) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);

        // FIFO return order, then enough rounds to wrap rd and wr.
        step(1'b0, 1'b0, 1'b1, 4'd5);
        step(1'b0, 1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b0, 1'b1, 4'd9);
        repeat (3) step(1'b0, 1'b1, 1'b0, '0);
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, AW'($urandom_range(0, DEPTH - 1)));
            repeat (3) step(1'b0, 1'b1, 1'b0, '0);
        end

        // Bypass on an empty pool.
        step(1'b0, 1'b1, 1'b1, 4'd7);
        step(1'b0, 1'b0, 1'b0, '0);

        // Fill to full, then rejected releases (including with a same-cycle grant).
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, AW'(i));
        step(1'b0, 1'b0, 1'b1, 4'd4);
        step(1'b0, 1'b1, 1'b1, 4'd2);
        repeat (5) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 4'd12);
        step(1'b0, 1'b0, 1'b1, 4'd15);

        // Low watermark: 6 -> 2 crosses on the 3->2 edge, release clears it.
        repeat (4) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 4'd1);

        // init_req at free_cnt=4 with ignored same-cycle requests.
        step(1'b0, 1'b0, 1'b1, 4'd6);
        step(1'b1, 1'b1, 1'b1, 4'd3);
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (DEPTH - 1) step(1'b0, 1'b0, 1'b0, '0);
        repeat (3) step(1'b0, 1'b1, 1'b0, '0);

        // Async reset in the middle of INIT.
        step(1'b1, 1'b0, 1'b0, '0);
        repeat (5) step(1'b0, 1'b0, 1'b0, '0);
        do_reset(1);
        repeat (DEPTH) step(1'b0, 1'b0, 1'b0, '0);
        repeat (2) step(1'b0, 1'b1, 1'b0, '0);

        // Random traffic, including out-of-range pointers and rare re-inits.
        repeat (400) begin
            step(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom),
                 AW'($urandom_range(0, 15)));
        end

        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
